// File: rtl/voting_pkg.sv
// Shared types and constants for the ballot collector and its tally.
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int BALLOT_W    = 8;
  localparam int VOTE_ID_W   = 3;
  localparam int MAX_VOTERS  = 7;
  localparam int CFG_BIT_IDX = 0;

endpackage

// File: rtl/voting_ballot_collector.sv
// Collects one vote per voter into a registered ballot for the tally, then
// returns the sampled tally result over a decision handshake.
module voting_ballot_collector
  import voting_pkg::*;
#(
  parameter int NUM_VOTERS     = 7,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  round_start,
  input  logic                  cfg_bit,
  input  logic                  vote_valid,
  output logic                  vote_ready,
  input  logic [VOTE_ID_W-1:0]  vote_id,
  input  logic                  vote_val,
  output logic [BALLOT_W-1:0]   tally_vec,
  input  logic                  tally_result,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic                  decision,
  output logic                  dec_timeout,
  output logic                  dup_err,
  output logic                  id_err,
  output logic [MAX_VOTERS-1:0] voted_mask,
  output state_t                dbg_state
);

  // Both handshakes are plain valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; vote_ready is high only in COLLECT.
  localparam logic [VOTE_ID_W-1:0]  MAX_ID    = VOTE_ID_W'(NUM_VOTERS);
  localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MAX_VOTERS-1:0] FULL_MASK = MAX_VOTERS'((1 << NUM_VOTERS) - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [MAX_VOTERS-1:0] r_mask;
  logic [BALLOT_W-1:0]   r_vec;
  logic                  r_dec_valid;
  logic                  r_decision;
  logic                  r_dec_timeout;
  logic                  r_dup_err;
  logic                  r_id_err;

  logic                  w_accept;
  logic                  w_id_bad;
  logic [VOTE_ID_W-1:0]  w_idx;
  logic                  w_dup;
  logic                  w_take;
  logic [MAX_VOTERS-1:0] w_onehot;
  logic [MAX_VOTERS-1:0] w_mask_next;
  logic                  w_full;

  assign w_accept    = vote_valid && (r_state == COLLECT);
  assign w_id_bad    = (vote_id == '0) || (vote_id > MAX_ID);
  assign w_idx       = vote_id - VOTE_ID_W'(1);
  // w_idx is out of range for id 0, so the mask lookup is gated by w_id_bad.
  assign w_dup       = !w_id_bad && r_mask[w_idx];
  assign w_take      = w_accept && !w_id_bad && !w_dup;
  assign w_onehot    = {{(MAX_VOTERS-1){1'b0}}, 1'b1} << w_idx;
  assign w_mask_next = r_mask | (w_take ? w_onehot : '0);
  assign w_full      = (w_mask_next == FULL_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_vec         <= '0;
      r_dec_valid   <= 1'b0;
      r_decision    <= 1'b0;
      r_dec_timeout <= 1'b0;
      r_dup_err     <= 1'b0;
      r_id_err      <= 1'b0;
    end else begin
      r_dup_err <= 1'b0;
      r_id_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (round_start) begin
            r_mask        <= '0;
            r_vec         <= BALLOT_W'(cfg_bit) << CFG_BIT_IDX;
            r_cnt         <= '0;
            r_dec_timeout <= 1'b0;
            r_state       <= COLLECT;
          end
        end
        COLLECT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_accept) begin
            if (w_id_bad) begin
              r_id_err <= 1'b1;
            end else if (w_dup) begin
              r_dup_err <= 1'b1;
            end else begin
              r_mask         <= w_mask_next;
              r_vec[vote_id] <= vote_val;
            end
          end
          // A completing vote wins over a timeout landing in the same cycle.
          if (w_full) begin
            r_dec_timeout <= 1'b0;
            r_state       <= EVAL;
          end else if (r_cnt == TO_LAST) begin
            r_dec_timeout <= 1'b1;
            r_state       <= EVAL;
          end
        end
        EVAL: begin
          r_decision  <= tally_result;
          r_dec_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (dec_ready) begin
            r_dec_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign vote_ready  = (r_state == COLLECT);
  assign tally_vec   = r_vec;
  assign dec_valid   = r_dec_valid;
  assign decision    = r_decision;
  assign dec_timeout = r_dec_timeout;
  assign dup_err     = r_dup_err;
  assign id_err      = r_id_err;
  assign voted_mask  = r_mask;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_voting_ballot_collector.sv
// Self-checking bench for voting_ballot_collector with a behavioural tally.
module tb_voting_ballot_collector;
  import voting_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       round_start;
  logic       cfg_bit;
  logic       vote_valid;
  logic       vote_ready;
  logic [2:0] vote_id;
  logic       vote_val;
  logic [7:0] tally_vec;
  logic       tally_result;
  logic       dec_valid;
  logic       dec_ready;
  logic       decision;
  logic       dec_timeout;
  logic       dup_err;
  logic       id_err;
  logic [6:0] voted_mask;
  state_t     dbg_state;

  always #5 clk = ~clk;

  voting_ballot_collector #(
    .NUM_VOTERS(7), .TIMEOUT_CYCLES(10), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .round_start(round_start), .cfg_bit(cfg_bit),
    .vote_valid(vote_valid), .vote_ready(vote_ready), .vote_id(vote_id),
    .vote_val(vote_val), .tally_vec(tally_vec), .tally_result(tally_result),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .decision(decision),
    .dec_timeout(dec_timeout), .dup_err(dup_err), .id_err(id_err),
    .voted_mask(voted_mask), .dbg_state(dbg_state)
  );

  // Stand-in tally: result is 1 when at least 4 ballot bits are set.
  function automatic logic tally_fn(input logic [7:0] v);
    return ($countones(v) >= 4);
  endfunction

  assign tally_result = tally_fn(tally_vec);

  typedef struct {
    logic [2:0] id;
    logic       val;
    logic       exp_dup;
    logic       exp_iderr;
  } vote_t;

  vote_t      tv[$];
  logic [1:0] exp_q[$];   // {dec_timeout, decision}
  logic [7:0] m_vec;
  logic [6:0] m_mask;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vote(input logic [2:0] id, input logic val, input logic d, input logic e);
    vote_t v;
    v.id = id; v.val = val; v.exp_dup = d; v.exp_iderr = e;
    tv.push_back(v);
  endtask

  task automatic start_round(input logic cfg);
    round_start = 1'b1;
    cfg_bit     = cfg;
    tick();
    round_start = 1'b0;
    m_vec  = {7'b0, cfg};
    m_mask = '0;
    chk("start_vote_ready", vote_ready, 1);
    chk("start_tally_vec", tally_vec, m_vec);
    chk("start_mask", voted_mask, m_mask);
  endtask

  task automatic drive_vote(input vote_t v);
    vote_valid = 1'b1;
    vote_id    = v.id;
    vote_val   = v.val;
    tick();
    vote_valid = 1'b0;
    if (!v.exp_dup && !v.exp_iderr) begin
      m_mask[int'(v.id) - 1] = 1'b1;
      m_vec[v.id]            = v.val;
    end
    chk($sformatf("dup_err_id%0d", v.id), dup_err, v.exp_dup);
    chk($sformatf("id_err_id%0d", v.id), id_err, v.exp_iderr);
    chk($sformatf("mask_id%0d", v.id), voted_mask, m_mask);
    chk($sformatf("vec_id%0d", v.id), tally_vec, m_vec);
  endtask

  task automatic apply_table();
    foreach (tv[i]) drive_vote(tv[i]);
    tv.delete();
  endtask

  task automatic wait_decision(input int budget, input int exp_lat);
    int c = 0;
    logic [1:0] e;
    while (!dec_valid && c < budget) begin
      tick();
      c++;
    end
    if (!dec_valid) begin
      n_total++;
      $display("FAIL dec_valid_wait: got none within %0d cycles", budget);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_lat >= 0) chk("dec_latency", c, exp_lat);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got decision with no expectation");
    end else begin
      e = exp_q.pop_front();
      chk("decision_timeout", {dec_timeout, decision}, e);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("dec_valid_clear", dec_valid, 0);
    chk("idle_after_hs", dbg_state, IDLE);
  endtask

  initial begin
    rst = 1'b1; round_start = 1'b0; cfg_bit = 1'b0; vote_valid = 1'b0;
    vote_id = '0; vote_val = 1'b0; dec_ready = 1'b0;
    m_vec = '0; m_mask = '0;
    repeat (3) tick();
    chk("rst_state", dbg_state, IDLE);
    chk("rst_vote_ready", vote_ready, 0);
    chk("rst_tally_vec", tally_vec, 0);
    chk("rst_mask", voted_mask, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_errs", {dup_err, id_err, dec_timeout, decision}, 0);
    rst = 1'b0;
    tick();

    // Full round, back-to-back votes
    start_round(1'b0);
    add_vote(1, 1, 0, 0); add_vote(2, 1, 0, 0); add_vote(3, 1, 0, 0);
    add_vote(4, 1, 0, 0); add_vote(5, 0, 0, 0); add_vote(6, 0, 0, 0);
    add_vote(7, 0, 0, 0);
    apply_table();
    chk("full_vec", tally_vec, 8'h1E);
    chk("full_mask", voted_mask, 7'h7F);
    chk("full_eval_no_valid", dec_valid, 0);
    exp_q.push_back({1'b0, tally_fn(8'h1E)});
    wait_decision(5, 1);

    // Duplicate and illegal ids
    start_round(1'b0);
    add_vote(3, 1, 0, 0); add_vote(3, 0, 1, 0); add_vote(0, 1, 0, 1);
    add_vote(1, 0, 0, 0); add_vote(2, 0, 0, 0); add_vote(4, 0, 0, 0);
    add_vote(5, 0, 0, 0); add_vote(6, 0, 0, 0); add_vote(7, 0, 0, 0);
    apply_table();
    chk("dup_vec", tally_vec, 8'h08);
    exp_q.push_back({1'b0, tally_fn(8'h08)});
    wait_decision(5, 1);

    // Timeout with a single vote
    start_round(1'b1);
    add_vote(2, 1, 0, 0);
    apply_table();
    repeat (8) tick();
    chk("to_still_collect", vote_ready, 1);
    tick();
    chk("to_eval_state", dbg_state, EVAL);
    chk("to_vec", tally_vec, 8'h05);
    exp_q.push_back({1'b1, tally_fn(8'h05)});
    wait_decision(5, 1);

    // Final vote lands in the same cycle as the timeout
    start_round(1'b0);
    add_vote(1, 1, 0, 0); add_vote(2, 0, 0, 0); add_vote(3, 1, 0, 0);
    add_vote(4, 0, 0, 0); add_vote(5, 1, 0, 0); add_vote(6, 0, 0, 0);
    apply_table();
    repeat (3) tick();
    chk("bnd_collect", vote_ready, 1);
    add_vote(7, 1, 0, 0);
    apply_table();
    chk("bnd_eval_state", dbg_state, EVAL);
    chk("bnd_vec", tally_vec, 8'hAA);
    exp_q.push_back({1'b0, tally_fn(8'hAA)});
    wait_decision(5, 1);

    // Backpressure on the decision, round_start ignored in HOLD
    start_round(1'b1);
    for (int i = 1; i <= 7; i++) add_vote(3'(i), 1'b1, 1'b0, 1'b0);
    apply_table();
    tick();
    chk("bp_dec_valid", dec_valid, 1);
    exp_q.push_back({1'b0, tally_fn(8'hFF)});
    for (int i = 0; i < 20; i++) begin
      round_start = (i % 5 == 0);
      cfg_bit     = 1'b0;
      tick();
      chk("bp_hold_valid", dec_valid, 1);
      chk("bp_hold_decision", {dec_timeout, decision}, {1'b0, tally_fn(8'hFF)});
      chk("bp_hold_vec", tally_vec, 8'hFF);
      chk("bp_no_ready", vote_ready, 0);
    end
    round_start = 1'b0;
    wait_decision(5, 0);
    tick();
    chk("bp_stays_idle", vote_ready, 0);

    // Reset in the middle of a round, then a normal round
    start_round(1'b1);
    add_vote(1, 1, 0, 0); add_vote(2, 1, 0, 0); add_vote(3, 1, 0, 0);
    add_vote(4, 1, 0, 0);
    apply_table();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", dbg_state, IDLE);
    chk("mid_rst_mask", voted_mask, 0);
    chk("mid_rst_vec", tally_vec, 0);
    chk("mid_rst_ready", vote_ready, 0);
    start_round(1'b0);
    for (int i = 1; i <= 7; i++) add_vote(3'(i), 1'(i % 2 == 0), 1'b0, 1'b0);
    apply_table();
    chk("post_rst_vec", tally_vec, 8'h54);
    exp_q.push_back({1'b0, tally_fn(8'h54)});
    wait_decision(5, 1);

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/voting_ballot_collector.md
Name: voting_ballot_collector

Overview:
- Upstream stage of the combinational 8-input voting tally.
- Collects one vote per voter over a valid/ready handshake, rejecting duplicate and out-of-range votes, with a round timeout.
- Drives a registered 8-bit ballot vector (bit 0 = round config bit, bits 1..7 = voter votes) into the tally.
- Samples the tally's 1-bit result and returns it through a valid/ready decision handshake.

Parameters:
- NUM_VOTERS, 7: voters per round; bits 1..NUM_VOTERS of the ballot; max 7.
- TIMEOUT_CYCLES, 255: COLLECT cycles before a forced close; must be >= 1.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- round_start  in  1  pulse that opens a round; honoured only in IDLE.
- cfg_bit  in  1  sampled on an accepted round_start into ballot bit 0.
- vote_valid  in  1  vote offered.
- vote_ready  out  1  high only in COLLECT.
- vote_id  in  3  voter index, legal 1..NUM_VOTERS.
- vote_val  in  1  vote value.
- tally_vec  out  8  registered ballot to the tally input.
- tally_result  in  1  combinational tally output.
- dec_valid  out  1  decision available.
- dec_ready  in  1  consumer accepts decision.
- decision  out  1  registered tally result.
- dec_timeout  out  1  round closed by timeout; valid with dec_valid.
- dup_err  out  1  one-cycle pulse: duplicate vote discarded.
- id_err  out  1  one-cycle pulse: illegal vote_id discarded.
- voted_mask  out  7  bit k-1 set once voter k has voted.

Behaviour:
- Reset:
  - State goes to IDLE.
  - tally_vec, voted_mask, decision, dec_valid, dec_timeout, dup_err, id_err and the counter all go to 0.
  - Reset in any state aborts the round; partial votes are lost.
- IDLE:
  - vote_ready=0.
  - On round_start: clear voted_mask, set tally_vec={7'b0, cfg_bit}, counter=0, clear dec_timeout, go to COLLECT.
- COLLECT:
  - vote_ready=1. A vote is accepted when vote_valid & vote_ready.
  - vote_id==0 or vote_id>NUM_VOTERS: discard, id_err=1 next cycle.
  - Voter already in voted_mask: discard, dup_err=1 next cycle. First vote wins.
  - Otherwise set voted_mask[id-1] and tally_vec[id]=vote_val on the next edge.
  - Counter increments every COLLECT cycle.
  - Mask becomes full (including via the vote accepted this cycle): go to EVAL, dec_timeout=0.
  - Else if counter==TIMEOUT_CYCLES-1: go to EVAL, dec_timeout=1. Missing voters remain 0 in tally_vec.
  - A final vote and timeout in the same cycle: the vote is accepted and dec_timeout=0.
- EVAL (exactly 1 cycle):
  - vote_ready=0; tally_vec is stable.
  - decision<=tally_result, dec_valid<=1, go to HOLD.
- HOLD:
  - dec_valid=1; decision, dec_timeout and tally_vec are held.
  - On dec_ready: dec_valid<=0, go to IDLE.
  - If dec_ready is already high on entry, the handshake completes in the first HOLD cycle.
- round_start is ignored outside IDLE.
- tally_vec changes only on an accepted vote or round_start, so the tally output is settled before EVAL.
- Latency: last accepted vote → dec_valid = 2 cycles. round_start → vote_ready = 1 cycle.
- dup_err and id_err are registered, single-cycle pulses. They are never set outside COLLECT.

Decomposition:
- Shared package voting_pkg holds:
  - state enum {IDLE, COLLECT, EVAL, HOLD};
  - BALLOT_W=8, VOTE_ID_W=3, MAX_VOTERS=7;
  - localparam CFG_BIT_IDX=0.
- No sub-module; the timeout counter and vote mask live inline.
- The tally stays a separate instance wired tally_vec→p_input, o→tally_result.

Test Plan:
- Full round: cfg_bit=0; votes id1..7 = 1,1,1,1,0,0,0 back-to-back → tally_vec=0x1E, voted_mask=0x7F, dec_valid 2 cycles after id7, decision = tally model(0x1E), dec_timeout=0.
- Duplicate and illegal: id3=1, id3=0, id0=1, then ids 1,2,4..7 = 0 → dup_err pulse after the second id3, id_err pulse after id0, tally_vec[3]=1, tally_vec=0x08.
- Timeout: TIMEOUT_CYCLES=10; cfg_bit=1; only id2=1 → EVAL after 10 COLLECT cycles, tally_vec=0x05, dec_timeout=1.
- Boundary: last voter accepted in the cycle counter==TIMEOUT_CYCLES-1 → vote recorded, dec_timeout=0.
- Backpressure: dec_ready held 0 for 20 cycles → dec_valid and decision stable; round_start pulses ignored; IDLE only after dec_ready=1.
- Reset mid-COLLECT after 4 votes → next cycle IDLE, voted_mask=0, tally_vec=0, vote_ready=0; a new round works normally.
